// File: rtl/nx_event_coalesce_if.sv
// Bundle of event inputs, shared configuration and coalesced outputs for nx_event_coalesce.
// The master side drives events and config. The slave side is the coalescer.
interface nx_event_coalesce_if #(
  parameter int N_INT_BITS = 16,
  parameter int CNT_W      = 8,
  parameter int TMR_W      = 16
);
  logic [N_INT_BITS-1:0] event_in;
  logic [N_INT_BITS-1:0] cfg_enable;
  logic [CNT_W-1:0]      cfg_threshold;
  logic [TMR_W-1:0]      cfg_timeout;
  logic                  flush;
  logic [N_INT_BITS-1:0] int_stb;
  logic [N_INT_BITS-1:0] pending;
  logic [N_INT_BITS-1:0] cnt_sat;

  modport master (
    output event_in, cfg_enable, cfg_threshold, cfg_timeout, flush,
    input  int_stb, pending, cnt_sat
  );

  modport slave (
    input  event_in, cfg_enable, cfg_threshold, cfg_timeout, flush,
    output int_stb, pending, cnt_sat
  );
endinterface

// File: rtl/nx_event_coalesce.sv
// Per-source interrupt event coalescer: one int_stb pulse per batch on threshold, timeout or flush.
// Strobe latency is 1 cycle from the firing evaluation; there is no backpressure, so events are never dropped while enabled.
module nx_event_coalesce #(
  parameter int N_INT_BITS = 16,
  parameter int CNT_W      = 8,
  parameter int TMR_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nx_event_coalesce_if.slave   io
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

  logic [N_INT_BITS-1:0] state_q, state_d;
  logic [N_INT_BITS-1:0] stb_q, stb_d;
  logic [N_INT_BITS-1:0] pending_q, pending_d;
  logic [N_INT_BITS-1:0] sat_q, sat_d;
  logic [CNT_W-1:0]      cnt_q [N_INT_BITS];
  logic [CNT_W-1:0]      cnt_d [N_INT_BITS];
  logic [TMR_W-1:0]      tmr_q [N_INT_BITS];
  logic [TMR_W-1:0]      tmr_d [N_INT_BITS];
  logic [CNT_W-1:0]      thr_eff;

  always_comb begin
    logic [CNT_W-1:0] cnt_nxt;
    logic             tmr_exp;
    logic             fire_acc;

    thr_eff   = (io.cfg_threshold == '0) ? CNT_ONE : io.cfg_threshold;
    state_d   = state_q;
    stb_d     = '0;
    pending_d = '0;
    sat_d     = sat_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    cnt_nxt   = '0;
    tmr_exp   = 1'b0;
    fire_acc  = 1'b0;

    for (int i = 0; i < N_INT_BITS; i++) begin
      cnt_nxt  = (io.event_in[i] && (cnt_q[i] != '1)) ? cnt_q[i] + 1'b1 : cnt_q[i];
      tmr_exp  = (io.cfg_timeout != '0) && (tmr_q[i] >= io.cfg_timeout);
      fire_acc = (cnt_nxt >= thr_eff) || tmr_exp || io.flush;

      if (!io.cfg_enable[i]) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
        tmr_d[i]   = '0;
        sat_d[i]   = 1'b0;
      end else if (state_q[i] == IDLE) begin
        if (io.event_in[i]) begin
          if (thr_eff == CNT_ONE) begin
            stb_d[i] = 1'b1;
          end else begin
            state_d[i]   = ACCUM;
            cnt_d[i]     = CNT_ONE;
            tmr_d[i]     = TMR_ONE;
            pending_d[i] = 1'b1;
          end
        end
      end else if (fire_acc) begin
        // pending stays up through the strobe cycle so the batch is never invisible
        stb_d[i]     = 1'b1;
        pending_d[i] = 1'b1;
        state_d[i]   = IDLE;
        cnt_d[i]     = '0;
        tmr_d[i]     = '0;
        sat_d[i]     = 1'b0;
      end else begin
        pending_d[i] = 1'b1;
        cnt_d[i]     = cnt_nxt;
        tmr_d[i]     = (tmr_q[i] == '1) ? tmr_q[i] : tmr_q[i] + 1'b1;
        sat_d[i]     = sat_q[i] | (cnt_nxt == '1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= '0;
      stb_q     <= '0;
      pending_q <= '0;
      sat_q     <= '0;
      cnt_q     <= '{default: '0};
      tmr_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      stb_q     <= stb_d;
      pending_q <= pending_d;
      sat_q     <= sat_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
    end
  end

  assign io.int_stb = stb_q;
  assign io.pending = pending_q;
  assign io.cnt_sat = sat_q;

endmodule

// File: tb/tb_nx_event_coalesce.sv
// Directed bench for nx_event_coalesce with a pulse/level scoreboard checked by a separate monitor.
// A second instance with CNT_W = 2 covers threshold truncation.
module tb_nx_event_coalesce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nx_event_coalesce_if #(.N_INT_BITS(16), .CNT_W(8), .TMR_W(16)) mif ();
  nx_event_coalesce_if #(.N_INT_BITS(16), .CNT_W(2), .TMR_W(16)) sif ();

  nx_event_coalesce #(.N_INT_BITS(16), .CNT_W(8), .TMR_W(16)) dut_m (
    .clk (clk),
    .rst (rst),
    .io  (mif.slave)
  );

  nx_event_coalesce #(.N_INT_BITS(16), .CNT_W(2), .TMR_W(16)) dut_s (
    .clk (clk),
    .rst (rst),
    .io  (sif.slave)
  );

  typedef struct {
    int          cyc;
    int          d;
    logic [15:0] val;
  } stb_exp_t;

  typedef struct {
    int          cyc;
    int          d;
    int          kind;
    logic [15:0] mask;
    logic [15:0] val;
    string       name;
  } lvl_exp_t;

  stb_exp_t stb_q[$];
  lvl_exp_t lvl_q[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 pending, 1 cnt_sat, 2 int_stb
  function automatic logic [15:0] sig(input int d, input int kind);
    logic [15:0] r;
    r = '0;
    if (d == 0) begin
      case (kind)
        0:       r = mif.pending;
        1:       r = mif.cnt_sat;
        default: r = mif.int_stb;
      endcase
    end else begin
      case (kind)
        0:       r = sif.pending;
        1:       r = sif.cnt_sat;
        default: r = sif.int_stb;
      endcase
    end
    return r;
  endfunction

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_stb(input int c, input int d, input logic [15:0] v);
    stb_exp_t e;
    e.cyc = c; e.d = d; e.val = v;
    stb_q.push_back(e);
  endtask

  task automatic exp_lvl(input int c, input int d, input int kind,
                         input logic [15:0] m, input logic [15:0] v, input string n);
    lvl_exp_t e;
    e.cyc = c; e.d = d; e.kind = kind; e.mask = m; e.val = v; e.name = n;
    lvl_q.push_back(e);
  endtask

  task automatic ev_m(input int c, input logic [15:0] m);
    goto(c);
    mif.event_in = m;
    goto(c + 1);
    mif.event_in = '0;
  endtask

  task automatic flush_m(input int c);
    goto(c);
    mif.flush = 1'b1;
    goto(c + 1);
    mif.flush = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [15:0] s;
    int found;
    for (int k = stb_q.size() - 1; k >= 0; k--) begin
      if (stb_q[k].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL stb_missed dut%0d cycle %0d: got no pulse, expected %h", stb_q[k].d, stb_q[k].cyc, stb_q[k].val);
        stb_q.delete(k);
      end
    end
    for (int d = 0; d < 2; d++) begin
      s = sig(d, 2);
      if (s != '0) begin
        found = -1;
        for (int k = 0; k < stb_q.size(); k++)
          if (found < 0 && stb_q[k].d == d && stb_q[k].cyc == cyc) found = k;
        checks++;
        if (found < 0) begin
          errors++;
          $display("FAIL stb_unexpected dut%0d cycle %0d: got %h, expected 0000", d, cyc, s);
        end else begin
          if (s != stb_q[found].val) begin
            errors++;
            $display("FAIL stb_value dut%0d cycle %0d: got %h, expected %h", d, cyc, s, stb_q[found].val);
          end
          stb_q.delete(found);
        end
      end
    end
    for (int k = lvl_q.size() - 1; k >= 0; k--) begin
      if (lvl_q[k].cyc == cyc) begin
        s = sig(lvl_q[k].d, lvl_q[k].kind) & lvl_q[k].mask;
        checks++;
        if (s != lvl_q[k].val) begin
          errors++;
          $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", lvl_q[k].name, lvl_q[k].d, cyc, s, lvl_q[k].val);
        end
        lvl_q.delete(k);
      end
    end
  end

  initial begin
    int b;
    logic [7:0] thr8;
    thr8 = 8'hFF;
    mif.event_in = '0; mif.cfg_enable = '1; mif.cfg_threshold = 8'd4;
    mif.cfg_timeout = 16'd0; mif.flush = 1'b0;
    sif.event_in = '0; sif.cfg_enable = '1; sif.cfg_threshold = thr8[1:0];
    sif.cfg_timeout = 16'd0; sif.flush = 1'b0;

    // reset state on both instances
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++) begin
        exp_lvl(3, d, k, 16'hFFFF, 16'h0000, "reset_state");
        exp_lvl(4, d, k, 16'hFFFF, 16'h0000, "reset_state");
      end
    goto(4);
    rst = 1'b0;

    // threshold 4, no timeout, sparse events on source 3
    b = 20;
    exp_stb(b + 21, 0, 16'h0008);
    exp_lvl(b + 10, 0, 0, 16'h0008, 16'h0000, "pend3_before");
    for (int c = b + 11; c <= b + 21; c++) exp_lvl(c, 0, 0, 16'h0008, 16'h0008, "pend3_held");
    exp_lvl(b + 22, 0, 0, 16'h0008, 16'h0000, "pend3_cleared");
    ev_m(b + 10, 16'h0008);
    ev_m(b + 12, 16'h0008);
    ev_m(b + 13, 16'h0008);
    ev_m(b + 20, 16'h0008);

    // timeout 5 on a single event, source 0
    b = 60;
    goto(b - 2);
    mif.cfg_threshold = 8'd8; mif.cfg_timeout = 16'd5;
    exp_stb(b + 16, 0, 16'h0001);
    exp_lvl(b + 15, 0, 0, 16'h0001, 16'h0001, "pend0_timeout");
    exp_lvl(b + 17, 0, 0, 16'h0001, 16'h0000, "pend0_after");
    ev_m(b + 10, 16'h0001);

    // threshold 1 and threshold 0: each event its own pulse, never pending
    for (int rep = 0; rep < 2; rep++) begin
      b = (rep == 0) ? 100 : 130;
      goto(b - 2);
      mif.cfg_threshold = (rep == 0) ? 8'd1 : 8'd0; mif.cfg_timeout = 16'd0;
      for (int k = 0; k < 4; k++) exp_stb(b + 11 + k, 0, 16'h0020);
      exp_lvl(b + 12, 0, 0, 16'h0020, 16'h0000, "pend5_thr1");
      goto(b + 10);
      mif.event_in = 16'h0020;
      goto(b + 14);
      mif.event_in = '0;
    end

    // flush fires partial batches on sources 1 and 2; later flush with nothing held
    b = 160;
    goto(b - 2);
    mif.cfg_threshold = 8'd3; mif.cfg_timeout = 16'd100;
    exp_stb(b + 9, 0, 16'h0006);
    exp_lvl(b + 8, 0, 0, 16'h0006, 16'h0006, "pend12_held");
    exp_lvl(b + 10, 0, 0, 16'h0006, 16'h0000, "pend12_flushed");
    ev_m(b + 5, 16'h0006);
    flush_m(b + 8);
    flush_m(b + 20);

    // timer reaches timeout in the same cycle as a second event: one pulse
    b = 200;
    goto(b - 2);
    mif.cfg_threshold = 8'd4; mif.cfg_timeout = 16'd4;
    exp_stb(b + 5, 0, 16'h0010);
    exp_lvl(b + 6, 0, 0, 16'h0010, 16'h0000, "pend4_absorbed");
    ev_m(b + 0, 16'h0010);
    ev_m(b + 4, 16'h0010);

    // enable dropped mid-batch: no pulse, pending cleared
    b = 220;
    exp_lvl(b + 1, 0, 0, 16'h0040, 16'h0040, "pend6_held");
    exp_lvl(b + 2, 0, 0, 16'h0040, 16'h0040, "pend6_held");
    exp_lvl(b + 3, 0, 0, 16'h0040, 16'h0000, "pend6_disabled");
    ev_m(b + 0, 16'h0040);
    goto(b + 2);
    mif.cfg_enable = 16'hFFBF;
    goto(b + 8);
    mif.cfg_enable = '1;

    // reset mid-batch discards it
    b = 240;
    exp_lvl(b + 2, 0, 0, 16'h0100, 16'h0100, "pend8_held");
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++) exp_lvl(b + 4, d, k, 16'hFFFF, 16'h0000, "midbatch_reset");
    ev_m(b + 0, 16'h0100);
    ev_m(b + 1, 16'h0100);
    goto(b + 3);
    rst = 1'b1;
    goto(b + 4);
    rst = 1'b0;

    // CNT_W = 2 instance, threshold 255 truncates to 3, continuous events on source 7
    b = 260;
    for (int k = 1; k <= 3; k++) exp_stb(b + 3 * k, 1, 16'h0080);
    for (int c = b + 1; c <= b + 10; c++) exp_lvl(c, 1, 1, 16'h0080, 16'h0000, "sat7_small");
    goto(b);
    sif.event_in = 16'h0080;
    goto(b + 9);
    sif.event_in = '0;

    // threshold 255 with 300 back-to-back events; remainder flushed
    b = 290;
    goto(b - 2);
    mif.cfg_threshold = 8'd255; mif.cfg_timeout = 16'd0;
    exp_stb(b + 255, 0, 16'h0080);
    exp_stb(b + 311, 0, 16'h0080);
    exp_lvl(b + 100, 0, 1, 16'h0080, 16'h0000, "sat7_midcount");
    exp_lvl(b + 255, 0, 0, 16'h0080, 16'h0080, "pend7_fire");
    exp_lvl(b + 256, 0, 0, 16'h0080, 16'h0080, "pend7_newbatch");
    exp_lvl(b + 312, 0, 0, 16'h0080, 16'h0000, "pend7_flushed");
    goto(b);
    mif.event_in = 16'h0080;
    goto(b + 300);
    mif.event_in = '0;
    flush_m(b + 310);
    goto(b + 320);
    @(negedge clk);
    @(negedge clk);

    for (int k = 0; k < stb_q.size(); k++) begin
      checks++;
      errors++;
      $display("FAIL stb_left dut%0d cycle %0d: got no pulse, expected %h", stb_q[k].d, stb_q[k].cyc, stb_q[k].val);
    end
    for (int k = 0; k < lvl_q.size(); k++) begin
      checks++;
      errors++;
      $display("FAIL %s_unchecked cycle %0d: got nothing, expected %h", lvl_q[k].name, lvl_q[k].cyc, lvl_q[k].val);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
